muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the single-issue core. It consumes the two operand values read from the register file (rs1/rs2 data) together with the destination index and funct3. It produces a single-cycle write-back beat (wr_ena/wr_addr/wr_data) that drives the register file write channel directly. One operation is in flight at a time; the issue logic stalls on `in_ready`.

---
 rtl/muldiv_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Handles one operation at a time. Multiplies use shift-add and divides use
// restoring division. Each retires one bit per cycle on unsigned magnitudes,
// and the sign is fixed up at the end. A divide by zero, and the signed
// overflow case, are resolved in the accept cycle and skip the iteration.
//
// Handshake: an operation transfers on the rising edge where
// in_valid && in_ready. in_ready is high only in IDLE, so in_valid is
// ignored while an operation is in flight. Operand inputs are sampled only
// in the accept cycle.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   : full divider datapath (DIV/DIVU/REM/REMU).
//   undefined : the divider is compiled out. Any funct3[2]=1 op completes
//               straight away with wr_data = 0.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     operation offered this cycle
//   in_ready     unit idle and able to accept
//   funct3       RV32M op select (000 MUL .. 111 REMU)
//   rs1_data     operand A (multiplicand / dividend)
//   rs2_data     operand B (multiplier / divisor)
//   rd_addr      destination register index
//   busy         operation in CALC or DONE
//   done         one-cycle result pulse
//   wr_ena       register-file write enable (done and wr_addr != 0)
//   wr_addr      registered destination index
//   wr_data      registered result
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [4:0]   rd_addr,
    output logic         busy,
    output logic         done,
    output logic         wr_ena,
    output logic [4:0]   wr_addr,
    output logic [N-1:0] wr_data
);

    localparam logic [2:0]   F_MULH   = 3'b001;
    localparam logic [2:0]   F_MULHSU = 3'b010;
    localparam logic [2:0]   F_DIV    = 3'b100;
    localparam logic [2:0]   F_REM    = 3'b110;
    localparam logic [5:0]   LAST_CNT = 6'(N - 1);
`ifdef MULDIV_DIV_EN
    localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic           accept;
    logic [2:0]     op_q;
    logic [4:0]     rd_q;
    logic           neg_q;
    logic [N-1:0]   opnd_q;     // multiplicand for multiply, divisor for divide
    logic [2*N-1:0] acc_q;      // product, or {remainder, dividend/quotient}
    logic [5:0]     cnt_q;

    // Accept-time decode
    logic           a_signed, b_signed, a_neg, b_neg, res_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic           special;
    logic [N-1:0]   special_data;

    // Iteration and result
    logic [N:0]     mul_sum;
    logic [2*N-1:0] acc_step;
    logic [2*N-1:0] prod_signed;
    logic [N-1:0]   calc_result;
`ifdef MULDIV_DIV_EN
    logic [N:0]     div_rem_sh;
    logic [N:0]     div_diff;
    logic [N-1:0]   div_res;
`endif

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign wr_ena   = done && (wr_addr != 5'd0);

    // Operand sign handling and special-case detection at accept
    always_comb begin
        a_signed     = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                       (funct3 == F_DIV)  || (funct3 == F_REM);
        b_signed     = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        a_neg        = a_signed && rs1_data[N-1];
        b_neg        = b_signed && rs2_data[N-1];
        a_mag        = a_neg ? (~rs1_data + 1'b1) : rs1_data;
        b_mag        = b_neg ? (~rs2_data + 1'b1) : rs2_data;
        // The remainder follows the dividend. Everything else follows the XOR of the signs.
        res_neg      = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
        special      = 1'b0;
        special_data = '0;
`ifdef MULDIV_DIV_EN
        if (funct3[2] && (rs2_data == '0)) begin
            special      = 1'b1;
            special_data = funct3[1] ? rs1_data : '1;
        end else if (((funct3 == F_DIV) || (funct3 == F_REM)) &&
                     (rs1_data == MIN_NEG) && (rs2_data == '1)) begin
            special      = 1'b1;
            special_data = funct3[1] ? '0 : MIN_NEG;
        end
`else
        special = funct3[2];
`endif
    end

    // One iteration step, and the signed result taken from the final step
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        acc_step = {mul_sum, acc_q[N-1:1]};
`ifdef MULDIV_DIV_EN
        // Shift the next dividend bit into the partial remainder and trial-subtract.
        // Bit N of the difference is the borrow.
        div_rem_sh = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff   = div_rem_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[N]) begin
                acc_step = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
            end else begin
                acc_step = {div_rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
            end
        end
`endif
        // The multiply sign is applied to the full double-width product before slicing
        prod_signed = neg_q ? (~acc_step + 1'b1) : acc_step;
        calc_result = (op_q[1:0] == 2'b00) ? prod_signed[N-1:0] : prod_signed[2*N-1:N];
`ifdef MULDIV_DIV_EN
        div_res = op_q[1] ? acc_step[2*N-1:N] : acc_step[N-1:0];
        if (op_q[2]) begin
            calc_result = neg_q ? (~div_res + 1'b1) : div_res;
        end
`else
        if (op_q[2]) begin
            calc_result = '0;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST_CNT) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= funct3;
                        rd_q   <= rd_addr;
                        neg_q  <= res_neg;
                        opnd_q <= funct3[2] ? b_mag : a_mag;
                        acc_q  <= {{N{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                        cnt_q  <= '0;
                        if (special) begin
                            wr_addr <= rd_addr;
                            wr_data <= special_data;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        wr_addr <= rd_q;
                        wr_data <= calc_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit (N = 32).
// The expected results come from plain 64-bit arithmetic on the RV32M rules.
// The bench follows the MULDIV_DIV_EN macro in the same way as the design.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] last_data;
    logic [4:0]  last_addr;

    muldiv_unit #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      la, lb, sp;
        logic [63:0] up;
        logic [31:0] r;
        r = '0;
        case (f)
            3'b000: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
            3'b001: begin la = $signed(a); lb = $signed(b); sp = la * lb; r = sp[63:32]; end
            3'b010: begin la = $signed(a); lb = {32'b0, b}; sp = la * lb; r = sp[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
`ifdef MULDIV_DIV_EN
            3'b100: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            3'b111: r = (b == 32'd0) ? a : a % b;
`else
            default: r = 32'd0;
`endif
        endcase
        return r;
    endfunction

    // Ops that complete in the accept cycle's successor with no iteration
    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return f[2] && ((b == 32'd0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return f[2];
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one op from IDLE, waits for its result (bounded), and checks the
    // latency, the write-back beat and the return to IDLE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        int          k;
        bit          special;
        logic [31:0] exp;
        special = is_special(f, a, b);
        exp_q.push_back(ref_model(f, a, b));
        @(negedge clk);
        check("ready_before_issue", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_addr  = rd;
        @(negedge clk);
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_addr  = 5'($urandom);
        if (!special) begin
            check("hold_data", wr_data, last_data);
            check("hold_addr", {27'b0, wr_addr}, {27'b0, last_addr});
        end
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        check("latency", k, special ? 32'd0 : 32'd32);
        exp = exp_q.pop_front();
        check("wr_data", wr_data, exp);
        check("wr_addr", {27'b0, wr_addr}, {27'b0, rd});
        check("wr_ena", {31'b0, wr_ena}, {31'b0, (rd != 5'd0)});
        last_data = exp;
        last_addr = rd;
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("wr_ena_one_cycle", {31'b0, wr_ena}, 32'd0);
        check("ready_after", {31'b0, in_ready}, 32'd1);
        check("data_held", wr_data, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_busy"},     {31'b0, busy},     32'd0);
        check({tag, "_done"},     {31'b0, done},     32'd0);
        check({tag, "_wr_ena"},   {31'b0, wr_ena},   32'd0);
        check({tag, "_wr_addr"},  {27'b0, wr_addr},  32'd0);
        check({tag, "_wr_data"},  wr_data,           32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   seen;
        logic [2:0] rf;
        checks    = 0;
        failures  = 0;
        last_data = '0;
        last_addr = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        funct3    = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        rd_addr   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed multiply cases
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8);
        run_op(3'b000, 32'd123, 32'd456, 5'd0);

        // Directed divide cases (constant zero results without the divider)
        run_op(3'b101, 32'd100, 32'd7, 5'd10);
        run_op(3'b111, 32'd100, 32'd7, 5'd11);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd12);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd13);
        run_op(3'b100, 32'd5, 32'd0, 5'd14);
        run_op(3'b110, 32'd5, 32'd0, 5'd15);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);

        // Reset ten cycles into a multiply discards it
        @(negedge clk);
        in_valid = 1'b1;
        funct3   = 3'b000;
        rs1_data = 32'd1000;
        rs2_data = 32'd1000;
        rd_addr  = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_mid_calc", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || wr_ena !== 1'b0) seen++;
        end
        check("no_result_after_reset", seen, 32'd0);
        last_data = '0;
        last_addr = '0;

        // Reset has priority over an offered op in IDLE
        in_valid = 1'b1;
        funct3   = 3'b000;
        rs1_data = 32'd2;
        rs2_data = 32'd2;
        rd_addr  = 5'd3;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("rst_priority");

        run_op(3'b000, 32'd3, 32'd4, 5'd4);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            run_op(rf, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
